// File: rtl/ram_fifo_pkg.sv
// Shared widths and controller state encoding for the RAM-backed FIFO.
package ram_fifo_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR_RD = 3'd3;
  localparam logic [2:0] ST_RD_WR = 3'd4;
endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer; rolls over naturally at 2**PTR_W.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int PTR_W = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);
  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer controller sequencing a passive word RAM into a FIFO.
// RAM strobes, address and write data are registered and held a full cycle.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err_ovf,
  output logic              err_udf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_r,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_d;
  logic              r_ram_r;
  logic              r_ram_w;

  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_wr_inc;
  logic              w_rd_inc;
  logic              w_full;
  logic              w_empty;

  assign w_full   = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Pointers advance at the end of the cycle that performs the access.
  assign w_wr_inc = (r_state == ST_WR) || (r_state == ST_WR_RD);
  assign w_rd_inc = (r_state == ST_RD) || (r_state == ST_RD_WR);

  ram_fifo_ptr #(.PTR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_inc),
    .o_ptr (w_wr_ptr)
  );

  ram_fifo_ptr #(.PTR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_inc),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_d     <= '0;
      r_ram_r     <= 1'b0;
      r_ram_w     <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_ram_r     <= 1'b0;
      r_ram_w     <= 1'b0;

      if (w_wr_inc)      r_count <= r_count + 1'b1;
      else if (w_rd_inc) r_count <= r_count - 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (push && pop) begin
            // ram_d doubles as the write-data latch for the deferred write.
            r_ram_d <= push_data;
            if (w_empty) begin
              r_state    <= ST_WR_RD;
              r_ram_w    <= 1'b1;
              r_ram_addr <= w_wr_ptr;
            end else begin
              r_state    <= ST_RD_WR;
              r_ram_r    <= 1'b1;
              r_ram_addr <= w_rd_ptr;
            end
          end else if (push) begin
            if (w_full) begin
              r_err_ovf <= 1'b1;
            end else begin
              r_state    <= ST_WR;
              r_ram_w    <= 1'b1;
              r_ram_addr <= w_wr_ptr;
              r_ram_d    <= push_data;
            end
          end else if (pop) begin
            if (w_empty) begin
              r_err_udf <= 1'b1;
            end else begin
              r_state    <= ST_RD;
              r_ram_r    <= 1'b1;
              r_ram_addr <= w_rd_ptr;
            end
          end
        end
        ST_WR: r_state <= ST_IDLE;
        ST_RD: begin
          r_state     <= ST_IDLE;
          r_pop_data  <= ram_o;
          r_pop_valid <= 1'b1;
        end
        ST_WR_RD: begin
          r_state    <= ST_RD;
          r_ram_r    <= 1'b1;
          r_ram_addr <= w_rd_ptr;
        end
        ST_RD_WR: begin
          r_state     <= ST_WR;
          r_pop_data  <= ram_o;
          r_pop_valid <= 1'b1;
          r_ram_w     <= 1'b1;
          r_ram_addr  <= w_wr_ptr;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign err_ovf   = r_err_ovf;
  assign err_udf   = r_err_udf;
  assign ram_addr  = r_ram_addr;
  assign ram_d     = r_ram_d;
  assign ram_r     = r_ram_r;
  assign ram_w     = r_ram_w;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural RAM and a data scoreboard.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid, ready, full, empty, err_ovf, err_udf;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d, ram_o;
  logic              ram_r, ram_w;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int wcnt   = 0;
  int wsnap;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_pop = '0;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  ram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .ready(ready), .full(full),
    .empty(empty), .count(count), .err_ovf(err_ovf), .err_udf(err_udf),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_r(ram_r), .ram_w(ram_w),
    .ram_o(ram_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w) begin
      mem[ram_addr] <= ram_d;
      wcnt <= wcnt + 1;
    end
  end
  assign ram_o = ram_r ? mem[ram_addr] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_r || ram_w) chk("ram_rw_excl", {31'd0, ram_r & ram_w}, 32'd0);
      if (pop_valid) begin
        if (exp_q.size() == 0) begin
          chk("pop_valid_unexpected", {31'd0, pop_valid}, 32'd0);
        end else begin
          last_pop = exp_q.pop_front();
          chk("pop_data", {16'd0, pop_data}, {16'd0, last_pop});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  task automatic op(input logic p, input logic q, input logic [DATA_W-1:0] v);
    wait_ready();
    push = p; pop = q; push_data = v;
    if (p && q) begin
      exp_q.push_back(v);
    end else if (p && m_cnt < 256) begin
      exp_q.push_back(v);
      m_cnt++;
    end else if (q && m_cnt > 0) begin
      m_cnt--;
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    wait_ready();
    chk("count", {23'd0, count}, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_outs", {ram_r, ram_w, pop_valid, err_ovf, err_udf}, 32'd0);
    chk("rst_pop_data", {16'd0, pop_data}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);

    // Underflow on an empty FIFO.
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("udf_pulse", {31'd0, err_udf}, 32'd1);
    chk("udf_no_read", {30'd0, ram_r, pop_valid}, 32'd0);
    chk("udf_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("udf_pulse_end", {31'd0, err_udf}, 32'd0);

    // Three pushes then three pops with latency checks.
    op(1, 0, 16'd128);
    op(1, 0, 16'd64);
    op(1, 0, 16'd11);
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      m_cnt--;
      @(posedge clk); #1;
      pop = 1'b0;
      chk("pop_rd_cycle", {ram_r, ram_w, ready, pop_valid}, 32'b1000);
      @(posedge clk); #1;
      chk("pop_valid_lat", {31'd0, pop_valid}, 32'd1);
      chk("pop_count", {23'd0, count}, m_cnt);
    end
    chk("pop_end_empty", {31'd0, empty}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("pop_data_hold", {16'd0, pop_data}, 32'd11);

    // Fill to full, then overflow.
    for (int i = 0; i < 256; i++) op(1, 0, DATA_W'(i));
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_count", {23'd0, count}, 32'd256);
    wsnap = wcnt;
    push = 1'b1; push_data = 16'd999;
    @(posedge clk); #1;
    push = 1'b0;
    chk("ovf_pulse", {31'd0, err_ovf}, 32'd1);
    chk("ovf_no_write", {31'd0, ram_w}, 32'd0);
    @(posedge clk); #1;
    chk("ovf_pulse_end", {31'd0, err_ovf}, 32'd0);
    chk("ovf_ram_untouched", wcnt, wsnap);
    chk("ovf_count", {23'd0, count}, 32'd256);
    op(1, 1, 16'd777);
    chk("full_rw_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 256; i++) op(0, 1, '0);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Pass-through on empty: WR then RD.
    push = 1'b1; pop = 1'b1; push_data = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    chk("pt_wr_phase", {ram_w, ram_r, pop_valid}, 32'b100);
    @(posedge clk); #1;
    chk("pt_rd_phase", {ram_w, ram_r, pop_valid}, 32'b010);
    @(posedge clk); #1;
    chk("pt_valid", {31'd0, pop_valid}, 32'd1);
    chk("pt_data", {16'd0, pop_data}, 32'hBEEF);
    chk("pt_count", {23'd0, count}, 32'd0);

    // Simultaneous on a partially filled FIFO.
    op(1, 0, 16'd5);
    op(1, 1, 16'd6);
    op(0, 1, '0);

    // Wrap-around of both pointers.
    do_reset();
    for (int i = 0; i < 200; i++) op(1, 0, DATA_W'(i + 3));
    for (int i = 0; i < 200; i++) op(0, 1, '0);
    for (int i = 0; i < 100; i++) op(1, 0, DATA_W'(1000 + i));
    for (int i = 0; i < 100; i++) op(0, 1, '0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Reset in the middle of a write.
    for (int i = 0; i < 5; i++) op(1, 0, DATA_W'(50 + i));
    chk("mid_count", {23'd0, count}, 32'd5);
    push = 1'b1; push_data = 16'd99;
    @(posedge clk); #1;
    push = 1'b0;
    chk("mid_in_wr", {31'd0, ram_w}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    chk("mid_rst_count", {23'd0, count}, 32'd0);
    chk("mid_rst_flags", {ram_w, ram_r, ready, empty}, 32'b0011);
    op(1, 0, 16'd7);
    op(0, 1, '0);
    chk("final_last_pop", {16'd0, pop_data}, 32'd7);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
